// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, instruction field positions and fetch state encoding shared by the control path
package cpu_pkg;

    localparam logic [5:0] OP_RFORMAT = 6'd0;
    localparam logic [5:0] OP_LW      = 6'd35;
    localparam logic [5:0] OP_SW      = 6'd43;
    localparam logic [5:0] OP_BEQ     = 6'd4;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;

    typedef enum logic [1:0] {RST, FETCH, ISSUE, WAIT_BR} fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction memory, issue and branch-resolve signals of the fetch unit
interface instr_fetch_unit_if #(parameter int ADDR_W = 32);

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              issue_valid;
    logic              issue_ready;
    logic [5:0]        op;
    logic [5:0]        funct;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [15:0]       imm;
    logic [ADDR_W-1:0] pc_plus4;
    logic              br_resolve_valid;
    logic              br_taken;
    logic [31:0]       instr_count;

    modport master (
        output imem_req, imem_addr, issue_valid, op, funct, rs, rt, rd, imm, pc_plus4, instr_count,
        input  imem_ack, imem_rdata, issue_ready, br_resolve_valid, br_taken
    );

    modport slave (
        input  imem_req, imem_addr, issue_valid, op, funct, rs, rt, rd, imm, pc_plus4, instr_count,
        output imem_ack, imem_rdata, issue_ready, br_resolve_valid, br_taken
    );

endinterface

// File: rtl/ifu_branch_target.sv
// ifu_branch_target: beq target = pc_plus4 + (sign-extended imm << 2), wrapping modulo 2^ADDR_W
module ifu_branch_target #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic [15:0]       imm,
    output logic [ADDR_W-1:0] target
);

    assign target = pc_plus4 + ADDR_W'($signed({imm, 2'b00}));

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches instructions, holds them for issue and owns the PC including beq redirection
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_unit_if.master  bus
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_plus4_q, pc_plus4_d;
    logic [31:0]       ir_q, ir_d;
    logic [31:0]       count_q, count_d;
    logic [ADDR_W-1:0] br_target;

    ifu_branch_target #(.ADDR_W(ADDR_W)) u_branch_target (
        .pc_plus4 (pc_plus4_q),
        .imm      (ir_q[IMM_MSB:IMM_LSB]),
        .target   (br_target)
    );

    assign bus.imem_addr   = pc_q;
    assign bus.op          = ir_q[OP_MSB:OP_LSB];
    assign bus.rs          = ir_q[RS_MSB:RS_LSB];
    assign bus.rt          = ir_q[RT_MSB:RT_LSB];
    assign bus.rd          = ir_q[RD_MSB:RD_LSB];
    assign bus.imm         = ir_q[IMM_MSB:IMM_LSB];
    assign bus.funct       = ir_q[FUNCT_MSB:FUNCT_LSB];
    assign bus.pc_plus4    = pc_plus4_q;
    assign bus.instr_count = count_q;

    // next-state, PC update and handshake outputs; a beq leaves ISSUE early only if already resolved
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        pc_plus4_d      = pc_plus4_q;
        ir_d            = ir_q;
        count_d         = count_q;
        bus.imem_req    = 1'b0;
        bus.issue_valid = 1'b0;
        case (state_q)
            RST: state_d = FETCH;
            FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ack) begin
                    ir_d       = bus.imem_rdata;
                    pc_plus4_d = pc_q + ADDR_W'(4);
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                bus.issue_valid = 1'b1;
                if (bus.issue_ready) begin
                    count_d = count_q + 32'd1;
                    if (ir_q[OP_MSB:OP_LSB] != OP_BEQ) begin
                        pc_d    = pc_plus4_q;
                        state_d = FETCH;
                    end else if (bus.br_resolve_valid) begin
                        pc_d    = bus.br_taken ? br_target : pc_plus4_q;
                        state_d = FETCH;
                    end else begin
                        state_d = WAIT_BR;
                    end
                end
            end
            WAIT_BR: begin
                if (bus.br_resolve_valid) begin
                    pc_d    = bus.br_taken ? br_target : pc_plus4_q;
                    state_d = FETCH;
                end
            end
            default: state_d = RST;
        endcase
    end

    // state, PC, instruction register and issue counter; reset aborts any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RST;
            pc_q       <= RESET_PC;
            pc_plus4_q <= '0;
            ir_q       <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            ir_q       <= ir_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of fetch, issue, branch redirection, PC wrap and reset abort
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_W(32)) ifa ();
    instr_fetch_unit_if #(.ADDR_W(32)) ifb ();

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa)
    );

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // one fetch with immediate ack followed by one issue with immediate ready
    task automatic issue_a(input logic [31:0] word, input logic bv, input logic bt);
        ifa.imem_ack = 1'b1;
        ifa.imem_rdata = word;
        step();
        ifa.imem_ack = 1'b0;
        ifa.issue_ready = 1'b1;
        ifa.br_resolve_valid = bv;
        ifa.br_taken = bt;
        step();
        ifa.issue_ready = 1'b0;
        ifa.br_resolve_valid = 1'b0;
        ifa.br_taken = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.imem_ack = 1'b0; ifa.imem_rdata = '0; ifa.issue_ready = 1'b0;
        ifa.br_resolve_valid = 1'b0; ifa.br_taken = 1'b0;
        ifb.imem_ack = 1'b0; ifb.imem_rdata = '0; ifb.issue_ready = 1'b0;
        ifb.br_resolve_valid = 1'b0; ifb.br_taken = 1'b0;
        repeat (2) step();
        check("rst_req", 32'(ifa.imem_req), 32'd0);
        check("rst_valid", 32'(ifa.issue_valid), 32'd0);
        check("rst_addr", ifa.imem_addr, 32'h0);
        check("rst_op", 32'(ifa.op), 32'd0);
        check("rst_funct", 32'(ifa.funct), 32'd0);
        check("rst_count", ifa.instr_count, 32'd0);
        rst_a = 1'b0;
        step();
        // lw with ack on the third request cycle
        for (int i = 0; i < 3; i++) begin
            check("lw_req", 32'(ifa.imem_req), 32'd1);
            check("lw_addr", ifa.imem_addr, 32'h0);
            if (i < 2) step();
        end
        ifa.imem_ack = 1'b1;
        ifa.imem_rdata = 32'h8C22_0004;
        step();
        ifa.imem_ack = 1'b0;
        check("lw_valid", 32'(ifa.issue_valid), 32'd1);
        check("lw_op", 32'(ifa.op), 32'd35);
        check("lw_rs", 32'(ifa.rs), 32'd1);
        check("lw_rt", 32'(ifa.rt), 32'd2);
        check("lw_imm", 32'(ifa.imm), 32'd4);
        check("lw_pc4", ifa.pc_plus4, 32'h4);
        ifa.issue_ready = 1'b1;
        step();
        ifa.issue_ready = 1'b0;
        check("lw_next_addr", ifa.imem_addr, 32'h4);
        check("lw_next_req", 32'(ifa.imem_req), 32'd1);
        check("lw_count", ifa.instr_count, 32'd1);
        check("lw_valid_drop", 32'(ifa.issue_valid), 32'd0);
        // R-format add held while ready is low
        ifa.imem_ack = 1'b1;
        ifa.imem_rdata = 32'h0022_1820;
        step();
        ifa.imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("add_valid", 32'(ifa.issue_valid), 32'd1);
            check("add_op", 32'(ifa.op), 32'd0);
            check("add_funct", 32'(ifa.funct), 32'h20);
            check("add_rd", 32'(ifa.rd), 32'd3);
            check("add_addr_hold", ifa.imem_addr, 32'h4);
            step();
        end
        ifa.issue_ready = 1'b1;
        step();
        ifa.issue_ready = 1'b0;
        check("add_next_addr", ifa.imem_addr, 32'h8);
        check("add_count", ifa.instr_count, 32'd2);
        issue_a(32'h0, 1'b0, 1'b0);
        issue_a(32'h0, 1'b0, 1'b0);
        check("nop_addr", ifa.imem_addr, 32'h10);
        // beq at 0x10, imm 3, taken, resolved two cycles after issue
        ifa.imem_ack = 1'b1;
        ifa.imem_rdata = 32'h1000_0003;
        step();
        ifa.imem_ack = 1'b0;
        check("beq_op", 32'(ifa.op), 32'd4);
        ifa.issue_ready = 1'b1;
        step();
        ifa.issue_ready = 1'b0;
        check("wait_valid", 32'(ifa.issue_valid), 32'd0);
        check("wait_req", 32'(ifa.imem_req), 32'd0);
        step();
        check("wait_req2", 32'(ifa.imem_req), 32'd0);
        ifa.br_resolve_valid = 1'b1;
        ifa.br_taken = 1'b1;
        step();
        ifa.br_resolve_valid = 1'b0;
        ifa.br_taken = 1'b0;
        check("beq_taken_addr", ifa.imem_addr, 32'h20);
        check("beq_taken_req", 32'(ifa.imem_req), 32'd1);
        // beq at 0x20, imm 0xFFFF, resolved in the handshake cycle: self loop
        issue_a(32'h1000_FFFF, 1'b1, 1'b1);
        check("beq_self_addr", ifa.imem_addr, 32'h20);
        check("beq_self_req", 32'(ifa.imem_req), 32'd1);
        check("beq_self_count", ifa.instr_count, 32'd6);
        issue_a(32'h1000_FFFB, 1'b1, 1'b1);
        check("beq_back_addr", ifa.imem_addr, 32'h10);
        // beq at 0x10 not taken; a resolve without handshake is ignored
        ifa.imem_ack = 1'b1;
        ifa.imem_rdata = 32'h1000_0003;
        step();
        ifa.imem_ack = 1'b0;
        ifa.br_resolve_valid = 1'b1;
        ifa.br_taken = 1'b1;
        step();
        check("beq_nohs_valid", 32'(ifa.issue_valid), 32'd1);
        check("beq_nohs_addr", ifa.imem_addr, 32'h10);
        ifa.br_resolve_valid = 1'b0;
        ifa.br_taken = 1'b0;
        ifa.issue_ready = 1'b1;
        step();
        ifa.issue_ready = 1'b0;
        check("beq_nt_wait", 32'(ifa.imem_req), 32'd0);
        step();
        ifa.br_resolve_valid = 1'b1;
        ifa.br_taken = 1'b0;
        step();
        ifa.br_resolve_valid = 1'b0;
        check("beq_nt_addr", ifa.imem_addr, 32'h14);
        check("beq_nt_count", ifa.instr_count, 32'd8);
        // resolve during FETCH is ignored
        ifa.br_resolve_valid = 1'b1;
        ifa.br_taken = 1'b1;
        step();
        check("fetch_ignore_addr", ifa.imem_addr, 32'h14);
        check("fetch_ignore_req", 32'(ifa.imem_req), 32'd1);
        // reset while waiting on ack; late ack is ignored
        ifa.br_resolve_valid = 1'b0;
        ifa.br_taken = 1'b0;
        rst_a = 1'b1;
        step();
        check("abort_req_rst", 32'(ifa.imem_req), 32'd0);
        rst_a = 1'b0;
        ifa.imem_ack = 1'b1;
        ifa.imem_rdata = 32'h8C22_0004;
        step();
        ifa.imem_ack = 1'b0;
        check("abort_addr", ifa.imem_addr, 32'h0);
        check("abort_count", ifa.instr_count, 32'd0);
        check("abort_valid", 32'(ifa.issue_valid), 32'd0);
        check("abort_op", 32'(ifa.op), 32'd0);
        step();
        check("abort_valid2", 32'(ifa.issue_valid), 32'd0);
        check("abort_req2", 32'(ifa.imem_req), 32'd1);
        // PC wrap from 0xFFFFFFFC
        rst_b = 1'b0;
        step();
        check("wrap_start_addr", ifb.imem_addr, 32'hFFFF_FFFC);
        ifb.imem_ack = 1'b1;
        ifb.imem_rdata = 32'h0022_1820;
        step();
        ifb.imem_ack = 1'b0;
        check("wrap_pc4", ifb.pc_plus4, 32'h0);
        ifb.issue_ready = 1'b1;
        step();
        ifb.issue_ready = 1'b0;
        check("wrap_addr", ifb.imem_addr, 32'h0);
        check("wrap_count", ifb.instr_count, 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
